sdes_stream_ctrl: RTL and testbench
===================================

Name: sdes_stream_ctrl

Overview:
Sequencing controller for the combinational S-DES byte core (sdes_encryption).
- Runs the 10-bit S-DES key schedule over two clocks into registered K1/K2.
- Accepts plaintext/ciphertext bytes on a valid/ready input port and drives the core with the correct key order.
- Buffers results in a small output FIFO with valid/ready back-pressure.
- Sits between the DE1-SoC I/O front end (switches/UART) and the display/output logic.

Parameters:
OUT_DEPTH, 4, output FIFO entries; power of two, minimum 2.

Ports:
i_clk  in  1  system clock, rising edge
i_rst_n  in  1  asynchronous active-low reset; all state clears immediately on assertion
i_key_load  in  1  one-cycle strobe to load i_key and run the key schedule
i_key  in  10  S-DES master key; bit 9 is key position 1
o_key_ready  out  1  K1/K2 are valid and the controller accepts data
i_valid  in  1  input byte valid
o_ready  out  1  controller can accept an input byte
i_data  in  8  input byte
i_decrypt  in  1  sampled with i_data: 0 = encrypt (K1,K2), 1 = decrypt (K2,K1)
o_valid  out  1  output FIFO not empty
i_ready  in  1  downstream accepts o_data
o_data  out  8  head of output FIFO

Behaviour:
- Reset values:
  - State is KEY_IDLE.
  - o_key_ready=0, o_ready=0, o_valid=0, o_data=0.
  - K1/K2 registers are 0, FIFO count is 0, in-flight flag is 0.
- FSM states:
  - KEY_IDLE: no valid key.
    - i_key_load=1 latches P10(i_key).
    - Applies LS-1 to each 5-bit half into the shift register.
    - Next state is KEY_GEN1.
  - KEY_GEN1: K1 <= P8(shift register); halves <= LS-2 of halves; next state is KEY_GEN2.
  - KEY_GEN2: K2 <= P8(halves); next state is RUN.
  - RUN: o_key_ready=1.
    - i_key_load=1 latches a new key as in KEY_IDLE and goes to KEY_GEN1.
- Permutation tables (positions 1..10, position 1 = MSB):
  - P10 = 3,5,2,7,4,10,1,9,8,6
  - P8 = 6,3,7,4,8,5,10,9
- Key-load timing: o_key_ready rises 3 clocks after the clock edge that samples i_key_load.
- Input handshake:
  - o_ready = (state==RUN) & !i_key_load & (fifo_count + inflight < OUT_DEPTH).
  - fifo_count and inflight are registered values.
  - A byte transfers on any rising edge with i_valid & o_ready.
  - On that edge i_data and i_decrypt are latched into the stage register and inflight is set.
- Core drive: the core sees the stage register.
  - Keys are (K1,K2) when decrypt=0 and (K2,K1) when decrypt=1.
- Pipeline: on the edge after acceptance, the core output is pushed into the FIFO and inflight clears.
  - A new byte may be accepted on that same edge, giving one byte per clock throughput.
- Latency: o_valid with the result is asserted 2 rising edges after the accepting edge, if the FIFO was empty.
- Output handshake:
  - An output transfer occurs on i_ready & o_valid.
  - o_data is stable while o_valid=1 and i_ready=0.
- Push and pop on the same edge: count is unchanged and ordering is preserved.
  - A pop when full does not raise o_ready until the next cycle, because o_ready uses the registered count.
- FIFO pointers wrap modulo OUT_DEPTH; count is 0..OUT_DEPTH, and overflow is impossible by construction.
- Key reload during RUN:
  - An in-flight byte completes with the old keys; K1/K2 change only in KEY_GEN1/KEY_GEN2.
  - Existing FIFO contents are retained and still drain during keygen.
  - i_key_load together with i_valid in the same cycle: key load wins, and the byte is not accepted.
- i_key_load in KEY_GEN1/KEY_GEN2 is ignored.
- Reset mid-operation: all state clears asynchronously, FIFO contents are lost, and a key must be reloaded.

Optional Feature:
SDES_BYTE_COUNT_EN:
- Defined:
  - Adds output port o_byte_count (16 bits).
  - Increments on every FIFO push.
  - Saturates at 16'hFFFF.
  - Clears on reset and on any accepted i_key_load.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Key schedule: reset, then i_key_load with i_key=10'b1010000010.
  - After 3 clocks o_key_ready=1.
  - Internal K1=8'b10100100, K2=8'b01000011.
- Encrypt: i_data=8'b10010111, i_decrypt=0 -> o_data=8'b00111000, o_valid asserted 2 edges after acceptance.
- Decrypt round-trip: i_data=8'b00111000, i_decrypt=1, same key -> o_data=8'b10010111.
- Back-pressure (OUT_DEPTH=4): hold i_ready=0 and stream 6 bytes.
  - Exactly 4 bytes are accepted, then o_ready=0.
  - Release i_ready and all bytes exit in order.
  - The remaining 2 bytes are accepted afterward.
- Key reload mid-stream: accept a byte, then assert i_key_load with a new key on the next edge.
  - The in-flight byte is encrypted with the old key.
  - o_ready=0 for 3 cycles.
  - Subsequent bytes use the new key.
  - A simultaneous i_valid on the load cycle is not accepted.
- Async reset: assert i_rst_n=0 mid-burst between clock edges.
  - o_valid, o_ready and o_key_ready go 0 immediately.
  - After release, data is refused until a key is loaded.

Source files
------------

// File: rtl/sdes_stream_ctrl.sv
// S-DES stream controller: two-clock key schedule, staged byte core and output FIFO.
// Optional byte counter enabled by defining SDES_BYTE_COUNT_EN.
module sdes_stream_ctrl #(
    parameter int OUT_DEPTH = 4
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_key_load,
    input  logic [9:0] i_key,
    output logic       o_key_ready,
    input  logic       i_valid,
    output logic       o_ready,
    input  logic [7:0] i_data,
    input  logic       i_decrypt,
    output logic       o_valid,
    input  logic       i_ready,
`ifdef SDES_BYTE_COUNT_EN
    output logic [15:0] o_byte_count,
`endif
    output logic [7:0] o_data
);

    localparam int PW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [PW-1:0] PTR_ONE  = 1;
    localparam logic [CW-1:0] CNT_ONE  = 1;
    localparam logic [CW-1:0] DEPTH_C  = CW'(OUT_DEPTH);

    typedef enum logic [1:0] {
        KEY_IDLE = 2'd0,
        KEY_GEN1 = 2'd1,
        KEY_GEN2 = 2'd2,
        RUN      = 2'd3
    } state_t;

    state_t        state_q;
    logic [9:0]    shift_q;
    logic [7:0]    k1_q;
    logic [7:0]    k2_q;
    logic          key_ready_q;
    logic [7:0]    stage_data_q;
    logic          stage_dec_q;
    logic          inflight_q;
    logic [7:0]    mem_q [OUT_DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic [CW-1:0] occupancy;
    logic          accept;
    logic          push;
    logic          pop;
    logic          key_load_acc;
    logic [7:0]    core_out;

    function automatic logic [9:0] p10(input logic [9:0] k);
        p10 = {k[7], k[5], k[8], k[3], k[6], k[0], k[9], k[1], k[2], k[4]};
    endfunction

    function automatic logic [7:0] p8(input logic [9:0] s);
        p8 = {s[4], s[7], s[3], s[6], s[2], s[5], s[0], s[1]};
    endfunction

    function automatic logic [9:0] ls1(input logic [9:0] s);
        ls1 = {s[8:5], s[9], s[3:0], s[4]};
    endfunction

    function automatic logic [9:0] ls2(input logic [9:0] s);
        ls2 = {s[7:5], s[9:8], s[2:0], s[4:3]};
    endfunction

    // Index is {row, col}: row from the outer bits, col from the inner bits.
    function automatic logic [1:0] sbox0(input logic [3:0] idx);
        case (idx)
            4'd0:  sbox0 = 2'd1;  4'd1:  sbox0 = 2'd0;  4'd2:  sbox0 = 2'd3;  4'd3:  sbox0 = 2'd2;
            4'd4:  sbox0 = 2'd3;  4'd5:  sbox0 = 2'd2;  4'd6:  sbox0 = 2'd1;  4'd7:  sbox0 = 2'd0;
            4'd8:  sbox0 = 2'd0;  4'd9:  sbox0 = 2'd2;  4'd10: sbox0 = 2'd1;  4'd11: sbox0 = 2'd3;
            4'd12: sbox0 = 2'd3;  4'd13: sbox0 = 2'd1;  4'd14: sbox0 = 2'd3;  4'd15: sbox0 = 2'd2;
            default: sbox0 = 2'd0;
        endcase
    endfunction

    function automatic logic [1:0] sbox1(input logic [3:0] idx);
        case (idx)
            4'd0:  sbox1 = 2'd0;  4'd1:  sbox1 = 2'd1;  4'd2:  sbox1 = 2'd2;  4'd3:  sbox1 = 2'd3;
            4'd4:  sbox1 = 2'd2;  4'd5:  sbox1 = 2'd0;  4'd6:  sbox1 = 2'd1;  4'd7:  sbox1 = 2'd3;
            4'd8:  sbox1 = 2'd3;  4'd9:  sbox1 = 2'd0;  4'd10: sbox1 = 2'd1;  4'd11: sbox1 = 2'd0;
            4'd12: sbox1 = 2'd2;  4'd13: sbox1 = 2'd1;  4'd14: sbox1 = 2'd0;  4'd15: sbox1 = 2'd3;
            default: sbox1 = 2'd0;
        endcase
    endfunction

    function automatic logic [7:0] fk(input logic [7:0] d, input logic [7:0] k);
        logic [7:0] x;
        logic [3:0] s;
        logic [3:0] f;
        x  = {d[0], d[3], d[2], d[1], d[2], d[1], d[0], d[3]} ^ k;
        s  = {sbox0({x[7], x[4], x[6], x[5]}), sbox1({x[3], x[0], x[2], x[1]})};
        f  = {s[2], s[0], s[1], s[3]};
        fk = {d[7:4] ^ f, d[3:0]};
    endfunction

    function automatic logic [7:0] sdes_byte(input logic [7:0] d, input logic [7:0] ka,
                                             input logic [7:0] kb);
        logic [7:0] t;
        t = fk({d[6], d[2], d[5], d[7], d[4], d[0], d[3], d[1]}, ka);
        t = fk({t[3:0], t[7:4]}, kb);
        sdes_byte = {t[4], t[7], t[5], t[3], t[1], t[6], t[0], t[2]};
    endfunction

    assign occupancy    = count_q + CW'(inflight_q);
    assign o_ready      = key_ready_q & ~i_key_load & (occupancy < DEPTH_C);
    assign accept       = i_valid & o_ready;
    assign push         = inflight_q;
    assign o_valid      = (count_q != {CW{1'b0}});
    assign pop          = i_ready & o_valid;
    assign o_data       = mem_q[rd_ptr_q];
    assign o_key_ready  = key_ready_q;
    assign key_load_acc = i_key_load & ((state_q == KEY_IDLE) | (state_q == RUN));
    assign core_out     = sdes_byte(stage_data_q,
                                    stage_dec_q ? k2_q : k1_q,
                                    stage_dec_q ? k1_q : k2_q);

    // FIFO occupancy next-state
    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // Key-schedule FSM; keys only change in the two generation states
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= KEY_IDLE;
            shift_q     <= 10'd0;
            k1_q        <= 8'd0;
            k2_q        <= 8'd0;
            key_ready_q <= 1'b0;
        end else begin
            case (state_q)
                KEY_IDLE, RUN: begin
                    if (i_key_load) begin
                        shift_q     <= ls1(p10(i_key));
                        state_q     <= KEY_GEN1;
                        key_ready_q <= 1'b0;
                    end else begin
                        key_ready_q <= (state_q == RUN);
                    end
                end
                KEY_GEN1: begin
                    k1_q    <= p8(shift_q);
                    shift_q <= ls2(shift_q);
                    state_q <= KEY_GEN2;
                end
                KEY_GEN2: begin
                    k2_q        <= p8(shift_q);
                    state_q     <= RUN;
                    key_ready_q <= 1'b1;
                end
                default: begin
                    state_q     <= KEY_IDLE;
                    key_ready_q <= 1'b0;
                end
            endcase
        end
    end

    // Stage register and output FIFO
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            stage_data_q <= 8'd0;
            stage_dec_q  <= 1'b0;
            inflight_q   <= 1'b0;
            wr_ptr_q     <= {PW{1'b0}};
            rd_ptr_q     <= {PW{1'b0}};
            count_q      <= {CW{1'b0}};
            for (int i = 0; i < OUT_DEPTH; i++) begin
                mem_q[i] <= 8'd0;
            end
        end else begin
            if (accept) begin
                stage_data_q <= i_data;
                stage_dec_q  <= i_decrypt;
            end
            inflight_q <= accept;
            if (push) begin
                mem_q[wr_ptr_q] <= core_out;
                wr_ptr_q        <= wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
            count_q <= count_d;
        end
    end

`ifdef SDES_BYTE_COUNT_EN
    logic [15:0] byte_cnt_q;

    // Push counter; a push coinciding with a key load starts the new count at one
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            byte_cnt_q <= 16'd0;
        end else if (key_load_acc) begin
            byte_cnt_q <= {15'd0, push};
        end else if (push && (byte_cnt_q != 16'hFFFF)) begin
            byte_cnt_q <= byte_cnt_q + 16'd1;
        end else begin
            byte_cnt_q <= byte_cnt_q;
        end
    end

    assign o_byte_count = byte_cnt_q;
`endif

endmodule

// File: tb/tb_sdes_stream_ctrl.sv
// Randomized bench for sdes_stream_ctrl against a table-driven S-DES reference
// and a queue model of the byte stream.
module tb_sdes_stream_ctrl;

    localparam int DEPTH = 4;
    localparam int T_P10 = 0, T_P8 = 1, T_IP = 2, T_IPI = 3, T_EP = 4, T_P4 = 5;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       key_load = 1'b0;
    logic [9:0] key = 10'd0;
    logic       valid = 1'b0;
    logic       dec = 1'b0;
    logic       rdy = 1'b0;
    logic [7:0] data = 8'd0;
    logic       key_ready, o_ready, o_valid;
    logic [7:0] o_data;
`ifdef SDES_BYTE_COUNT_EN
    logic [15:0] byte_count;
`endif

    sdes_stream_ctrl #(.OUT_DEPTH(DEPTH)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_key_load(key_load), .i_key(key),
        .o_key_ready(key_ready), .i_valid(valid), .o_ready(o_ready),
        .i_data(data), .i_decrypt(dec), .o_valid(o_valid), .i_ready(rdy),
`ifdef SDES_BYTE_COUNT_EN
        .o_byte_count(byte_count),
`endif
        .o_data(o_data)
    );

    always #5 clk = ~clk;

    int PT [6][10] = '{
        '{3, 5, 2, 7, 4, 10, 1, 9, 8, 6},
        '{6, 3, 7, 4, 8, 5, 10, 9, 0, 0},
        '{2, 6, 3, 1, 4, 8, 5, 7, 0, 0},
        '{4, 1, 3, 5, 7, 2, 8, 6, 0, 0},
        '{4, 1, 2, 3, 2, 3, 4, 1, 0, 0},
        '{2, 4, 3, 1, 0, 0, 0, 0, 0, 0}
    };
    int S0_T [4][4] = '{'{1, 0, 3, 2}, '{3, 2, 1, 0}, '{0, 2, 1, 3}, '{3, 1, 3, 2}};
    int S1_T [4][4] = '{'{0, 1, 2, 3}, '{2, 0, 1, 3}, '{3, 0, 1, 0}, '{2, 1, 0, 3}};

    int checks = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", tag, act, exp);
        end
    endtask

    function automatic logic [9:0] perm(input logic [9:0] in, input int nin, input int tbl,
                                        input int nout);
        logic [9:0] r;
        r = 10'd0;
        for (int i = 0; i < nout; i++) r[nout - 1 - i] = in[nin - PT[tbl][i]];
        return r;
    endfunction

    function automatic logic [3:0] m_f(input logic [3:0] r, input logic [7:0] k);
        logic [9:0] t;
        logic [7:0] x;
        int s0v, s1v;
        logic [3:0] sv;
        t   = perm({6'd0, r}, 4, T_EP, 8);
        x   = t[7:0] ^ k;
        s0v = S0_T[{x[7], x[4]}][{x[6], x[5]}];
        s1v = S1_T[{x[3], x[0]}][{x[2], x[1]}];
        sv  = {s0v[1:0], s1v[1:0]};
        t   = perm({6'd0, sv}, 4, T_P4, 4);
        return t[3:0];
    endfunction

    function automatic logic [7:0] m_crypt(input logic [7:0] d, input logic [7:0] ka,
                                           input logic [7:0] kb);
        logic [9:0] t;
        logic [3:0] l, r, tmp;
        t   = perm({2'b00, d}, 8, T_IP, 8);
        l   = t[7:4];
        r   = t[3:0];
        l   = l ^ m_f(r, ka);
        tmp = l; l = r; r = tmp;
        l   = l ^ m_f(r, kb);
        t   = perm({2'b00, l, r}, 8, T_IPI, 8);
        return t[7:0];
    endfunction

    task automatic m_keys(input logic [9:0] k, output logic [7:0] k1, output logic [7:0] k2);
        logic [9:0] p, t;
        logic [4:0] l, r;
        p  = perm(k, 10, T_P10, 10);
        l  = p[9:5];
        r  = p[4:0];
        l  = {l[3:0], l[4]};
        r  = {r[3:0], r[4]};
        t  = perm({l, r}, 10, T_P8, 8);
        k1 = t[7:0];
        l  = {l[2:0], l[4:3]};
        r  = {r[2:0], r[4:3]};
        t  = perm({l, r}, 10, T_P8, 8);
        k2 = t[7:0];
    endtask

    typedef struct {
        logic [7:0] d;
        int         vis;
    } ent_t;

    ent_t        q[$];
    int          edge_cnt = 0;
    bit          has_key = 1'b0;
    int          kr_edge = 0;
    logic [7:0]  mk1 = 8'd0, mk2 = 8'd0;
    int          acc_cnt = 0, out_cnt = 0;
    logic [15:0] bc_m = 16'd0;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // Reference model: sampled on the falling edge, predicts the coming rising edge
    initial begin
        int   n;
        bit   kr, kg, er, ev, push_now;
        ent_t e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                n  = edge_cnt;
                kr = has_key && (n >= kr_edge);
                kg = has_key && (n < kr_edge);
                er = kr && !key_load && (q.size() < DEPTH);
                ev = (q.size() > 0) && (q[0].vis <= n);
                check_eq("key_ready", {31'd0, key_ready}, {31'd0, kr});
                check_eq("o_ready", {31'd0, o_ready}, {31'd0, er});
                check_eq("o_valid", {31'd0, o_valid}, {31'd0, ev});
                if (ev && o_valid) check_eq("o_data", {24'd0, o_data}, {24'd0, q[0].d});
                push_now = (q.size() > 0) && (q[q.size() - 1].vis == n + 1);
`ifdef SDES_BYTE_COUNT_EN
                check_eq("byte_count", {16'd0, byte_count}, {16'd0, bc_m});
                if (key_load && !kg) bc_m = {15'd0, push_now};
                else if (push_now && bc_m != 16'hFFFF) bc_m = bc_m + 16'd1;
`endif
                if (ev && rdy) begin
                    void'(q.pop_front());
                    out_cnt++;
                end
                if (er && valid) begin
                    e.d   = dec ? m_crypt(data, mk2, mk1) : m_crypt(data, mk1, mk2);
                    e.vis = n + 2;
                    q.push_back(e);
                    acc_cnt++;
                end
                if (key_load && !kg) begin
                    m_keys(key, mk1, mk2);
                    has_key = 1'b1;
                    kr_edge = n + 3;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int a0, o0;
        repeat (2) step();
        check_eq("rst_key_ready", {31'd0, key_ready}, 32'd0);
        check_eq("rst_o_ready", {31'd0, o_ready}, 32'd0);
        check_eq("rst_o_valid", {31'd0, o_valid}, 32'd0);
        check_eq("rst_o_data", {24'd0, o_data}, 32'd0);
        rst_n = 1'b1;

        // data refused before any key
        valid = 1'b1; data = 8'h55;
        repeat (2) step();
        valid = 1'b0;

        // key schedule with the reference key
        key = 10'b1010000010; key_load = 1'b1;
        step();
        key_load = 1'b0;
        check_eq("kr_after_gen1", {31'd0, key_ready}, 32'd0);
        step();
        check_eq("kr_after_gen2", {31'd0, key_ready}, 32'd0);
        step();
        check_eq("kr_run", {31'd0, key_ready}, 32'd1);

        // known-answer encrypt and decrypt
        rdy = 1'b1; data = 8'b10010111; dec = 1'b0; valid = 1'b1;
        step();
        valid = 1'b0;
        check_eq("enc_valid_early", {31'd0, o_valid}, 32'd0);
        step();
        check_eq("enc_valid", {31'd0, o_valid}, 32'd1);
        check_eq("enc_vec", {24'd0, o_data}, {24'd0, 8'b00111000});
        data = 8'b00111000; dec = 1'b1; valid = 1'b1;
        step();
        valid = 1'b0;
        step();
        check_eq("dec_valid", {31'd0, o_valid}, 32'd1);
        check_eq("dec_vec", {24'd0, o_data}, {24'd0, 8'b10010111});
        step();

        // back-pressure: 6 offered, 4 accepted, drain, then the last 2
        rdy = 1'b0; a0 = acc_cnt;
        for (int i = 0; i < 6; i++) begin
            valid = 1'b1; data = 8'($urandom); dec = 1'($urandom);
            step();
        end
        valid = 1'b0;
        check_eq("bp_accepted", acc_cnt - a0, 32'd4);
        check_eq("bp_ready_low", {31'd0, o_ready}, 32'd0);
        o0 = out_cnt; rdy = 1'b1;
        repeat (6) step();
        check_eq("bp_drained", out_cnt - o0, 32'd4);
        a0 = acc_cnt;
        for (int i = 0; i < 2; i++) begin
            valid = 1'b1; data = 8'($urandom); dec = 1'($urandom);
            step();
        end
        valid = 1'b0;
        check_eq("bp_rest", acc_cnt - a0, 32'd2);
        repeat (4) step();

        // key reload right after an accepted byte
        valid = 1'b1; data = 8'hA5; dec = 1'b0;
        step();
        a0 = acc_cnt;
        key_load = 1'b1; key = 10'b0111001101; data = 8'h3C;
        step();
        key_load = 1'b0;
        check_eq("reload_no_accept", acc_cnt - a0, 32'd0);
        check_eq("reload_ready_g1", {31'd0, o_ready}, 32'd0);
        step();
        check_eq("reload_ready_g2", {31'd0, o_ready}, 32'd0);
        step();
        check_eq("reload_ready_run", {31'd0, o_ready}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            data = 8'($urandom); dec = 1'($urandom);
            step();
        end
        valid = 1'b0;
        repeat (4) step();

        // randomized traffic with occasional key loads
        for (int i = 0; i < 400; i++) begin
            valid    = 1'($urandom);
            data     = 8'($urandom);
            dec      = 1'($urandom);
            rdy      = ($urandom_range(3) != 0);
            key_load = ($urandom_range(49) == 0);
            key      = 10'($urandom);
            step();
        end
        key_load = 1'b0; valid = 1'b0; rdy = 1'b1;
        repeat (10) step();

        // asynchronous reset in the middle of a burst
        rdy = 1'b0; valid = 1'b1;
        repeat (3) step();
        #1;
        rst_n = 1'b0;
        #1;
        check_eq("arst_o_valid", {31'd0, o_valid}, 32'd0);
        check_eq("arst_o_ready", {31'd0, o_ready}, 32'd0);
        check_eq("arst_key_ready", {31'd0, key_ready}, 32'd0);
        q.delete(); has_key = 1'b0; bc_m = 16'd0;
        repeat (2) step();
        rst_n = 1'b1;
        a0 = acc_cnt;
        repeat (3) step();
        valid = 1'b0;
        check_eq("arst_refuse", acc_cnt - a0, 32'd0);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
